// File: rtl/imem_loader_if.sv
// ============================================================================
// Module  : imem_loader_if
// Brief   : Byte-stream, instruction-memory write and status bundle for imem_loader.
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

interface imem_loader_if;
  logic        byte_valid;
  logic [7:0]  byte_data;
  logic        byte_ready;
  logic        imem_we;
  logic [31:0] imem_addr;
  logic [31:0] imem_wdata;
  logic        cpu_hold;
  logic        load_done;
  logic        load_error;
  logic [15:0] word_count;

  modport slave (
    input  byte_valid, byte_data,
    output byte_ready, imem_we, imem_addr, imem_wdata,
    output cpu_hold, load_done, load_error, word_count
  );

  modport master (
    output byte_valid, byte_data,
    input  byte_ready, imem_we, imem_addr, imem_wdata,
    input  cpu_hold, load_done, load_error, word_count
  );
endinterface

`default_nettype wire

// File: rtl/imem_loader.sv
// ============================================================================
// Module  : imem_loader
// Brief   : Boot loader: byte stream -> big-endian words -> imem writes; holds CPU until done.
//           Optional trailing XOR checksum byte: define IMEM_LOADER_CHECKSUM_EN.
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

module imem_loader #(
  parameter int          DEPTH_WORDS = 1024,
  parameter logic [31:0] BASE_ADDR   = 32'h0000_0000
) (
  input  wire logic Clk,
  input  wire logic Reset,
  imem_loader_if.slave bus
);

  typedef enum logic [2:0] {
    S_HDR_HI = 3'd0,
    S_HDR_LO = 3'd1,
    S_WORD   = 3'd2,
    S_WRITE  = 3'd3,
`ifdef IMEM_LOADER_CHECKSUM_EN
    S_CHK    = 3'd4,
`endif
    S_DONE   = 3'd5,
    S_ERR    = 3'd6
  } state_t;

  localparam logic [31:0] C_DEPTH = 32'(DEPTH_WORDS);
`ifdef IMEM_LOADER_CHECKSUM_EN
  localparam state_t C_AFTER_LAST = S_CHK;
`else
  localparam state_t C_AFTER_LAST = S_DONE;
`endif

  state_t      r_state;
  state_t      w_next;
  logic [15:0] r_n;
  logic [1:0]  r_idx;
  logic [31:0] r_wdata;
  logic [31:0] r_addr;
  logic [15:0] r_count;
  logic        w_ready;
  logic        w_acc;
  logic [15:0] w_n_hdr;
`ifdef IMEM_LOADER_CHECKSUM_EN
  logic [7:0]  r_xor;
`endif

  always_comb begin
    w_ready = (r_state == S_HDR_HI) || (r_state == S_HDR_LO) || (r_state == S_WORD)
`ifdef IMEM_LOADER_CHECKSUM_EN
              || (r_state == S_CHK)
`endif
              ;
  end

  assign w_acc   = bus.byte_valid && w_ready;
  assign w_n_hdr = {r_n[15:8], bus.byte_data};

  always_ff @(posedge Clk) begin
    if (Reset) r_state <= S_HDR_HI;
    else       r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_HDR_HI: if (w_acc) w_next = S_HDR_LO;
      S_HDR_LO: begin
        if (w_acc) begin
          if ({16'd0, w_n_hdr} > C_DEPTH) w_next = S_ERR;
          else if (w_n_hdr == 16'd0)      w_next = C_AFTER_LAST;
          else                            w_next = S_WORD;
        end
      end
      S_WORD:   if (w_acc && (r_idx == 2'd3)) w_next = S_WRITE;
      S_WRITE:  w_next = ((r_count + 16'd1) == r_n) ? C_AFTER_LAST : S_WORD;
`ifdef IMEM_LOADER_CHECKSUM_EN
      S_CHK:    if (w_acc) w_next = (bus.byte_data == r_xor) ? S_DONE : S_ERR;
`endif
      default:  w_next = r_state;
    endcase
  end

  // Header, shift register and write pointer; a reset discards any partial word.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      r_n     <= 16'd0;
      r_idx   <= 2'd0;
      r_wdata <= 32'd0;
      r_addr  <= BASE_ADDR;
      r_count <= 16'd0;
    end else begin
      if (w_acc && (r_state == S_HDR_HI)) r_n[15:8] <= bus.byte_data;
      if (w_acc && (r_state == S_HDR_LO)) r_n[7:0]  <= bus.byte_data;
      if (w_acc && (r_state == S_WORD)) begin
        r_wdata <= {r_wdata[23:0], bus.byte_data};
        r_idx   <= r_idx + 2'd1;
      end
      if (r_state == S_WRITE) begin
        r_count <= r_count + 16'd1;
        r_addr  <= r_addr + 32'd4;
      end
    end
  end

`ifdef IMEM_LOADER_CHECKSUM_EN
  // Running XOR covers header and payload, never the checksum byte itself.
  always_ff @(posedge Clk) begin
    if (Reset)                             r_xor <= 8'd0;
    else if (w_acc && (r_state != S_CHK)) r_xor <= r_xor ^ bus.byte_data;
  end
`endif

  assign bus.byte_ready = w_ready;
  assign bus.imem_we    = (r_state == S_WRITE);
  assign bus.imem_addr  = r_addr;
  assign bus.imem_wdata = r_wdata;
  assign bus.cpu_hold   = (r_state != S_DONE);
  assign bus.load_done  = (r_state == S_DONE);
  assign bus.load_error = (r_state == S_ERR);
  assign bus.word_count = r_count;

endmodule

`default_nettype wire
